// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states and width defaults.
package load_store_unit_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int REG_WIDTH_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: selects the byte/half lane from the read word and extends it.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] wb_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by sign or zero extension to the full register width.
    always_comb begin
        byte_s  = rdata[7:0];
        half_s  = rdata[15:0];
        wb_data = {WIDTH{1'b0}};
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_LB:   wb_data = {{(WIDTH-8){byte_s[7]}}, byte_s};
            F3_LH:   wb_data = {{(WIDTH-16){half_s[15]}}, half_s};
            F3_LW:   wb_data = rdata;
            F3_LBU:  wb_data = {{(WIDTH-8){1'b0}}, byte_s};
            F3_LHU:  wb_data = {{(WIDTH-16){1'b0}}, half_s};
            default: wb_data = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one LOAD/STORE at a time over a req/gnt/rvalid data-memory handshake,
// with store lane steering, alignment checking and aligned load writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [WIDTH-1:0]     addr,
    input  logic [WIDTH-1:0]     store_data,
    input  logic [REG_WIDTH-1:0] rd,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 wb_valid,
    output logic [REG_WIDTH-1:0] wb_rd,
    output logic [WIDTH-1:0]     wb_data,
    output logic                 access_err
);

    logic [1:0]           state_r;
    logic                 in_ready_r;
    logic                 is_store_r;
    logic [2:0]           funct3_r;
    logic [1:0]           addr_lo_r;
    logic [REG_WIDTH-1:0] rd_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic [WIDTH-1:0]     mem_addr_r;
    logic [WIDTH-1:0]     mem_wdata_r;
    logic [3:0]           mem_wstrb_r;
    logic                 wb_valid_r;
    logic [REG_WIDTH-1:0] wb_rd_r;
    logic [WIDTH-1:0]     wb_data_r;
    logic                 access_err_r;

    logic                 illegal_s;
    logic [WIDTH-1:0]     wdata_s;
    logic [3:0]           wstrb_s;
    logic [WIDTH-1:0]     align_s;

    // Misalignment and unsupported-funct3 detection on the incoming request.
    always_comb begin
        illegal_s = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB:   illegal_s = 1'b0;
                F3_SH:   illegal_s = addr[0];
                F3_SW:   illegal_s = (addr[1:0] != 2'b00);
                default: illegal_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: illegal_s = 1'b0;
                F3_LH, F3_LHU: illegal_s = addr[0];
                F3_LW:         illegal_s = (addr[1:0] != 2'b00);
                default:       illegal_s = 1'b1;
            endcase
        end
    end

    // Store lane steering: replicate the datum into every lane, enable only the addressed ones.
    always_comb begin
        wdata_s = store_data;
        wstrb_s = 4'b0000;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wdata_s = {4{store_data[7:0]}};
                    wstrb_s = 4'b0001 << addr[1:0];
                end
                F3_SH: begin
                    wdata_s = {2{store_data[15:0]}};
                    wstrb_s = addr[1] ? 4'b1100 : 4'b0011;
                end
                F3_SW: begin
                    wdata_s = store_data;
                    wstrb_s = 4'b1111;
                end
                default: begin
                    wdata_s = store_data;
                    wstrb_s = 4'b0000;
                end
            endcase
        end else begin
            wdata_s = store_data;
            wstrb_s = 4'b0000;
        end
    end

    // Aligns mem_rdata directly so the response can be captured the cycle it arrives.
    load_store_unit_load_align #(
        .WIDTH (WIDTH)
    ) u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_r),
        .funct3  (funct3_r),
        .wb_data (align_s)
    );

    // Access FSM; all outputs are registered and the pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            is_store_r   <= 1'b0;
            funct3_r     <= 3'b000;
            addr_lo_r    <= 2'b00;
            rd_r         <= {REG_WIDTH{1'b0}};
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {WIDTH{1'b0}};
            mem_wdata_r  <= {WIDTH{1'b0}};
            mem_wstrb_r  <= 4'b0000;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= {REG_WIDTH{1'b0}};
            wb_data_r    <= {WIDTH{1'b0}};
            access_err_r <= 1'b0;
        end else begin
            wb_valid_r   <= 1'b0;
            access_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_store_r <= is_store;
                        funct3_r   <= funct3;
                        addr_lo_r  <= addr[1:0];
                        rd_r       <= rd;
                        in_ready_r <= 1'b0;
                        if (illegal_s) begin
                            access_err_r <= 1'b1;
                            state_r      <= ST_RESP;
                        end else begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= is_store;
                            mem_addr_r  <= {addr[WIDTH-1:2], 2'b00};
                            mem_wdata_r <= wdata_s;
                            mem_wstrb_r <= wstrb_s;
                            state_r     <= ST_REQ;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_wstrb_r <= 4'b0000;
                        if (is_store_r) begin
                            in_ready_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else if (mem_rvalid) begin
                            wb_data_r  <= align_s;
                            wb_rd_r    <= rd_r;
                            wb_valid_r <= 1'b1;
                            state_r    <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        wb_data_r  <= align_s;
                        wb_rd_r    <= rd_r;
                        wb_valid_r <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_req_r   <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_wstrb_r <= 4'b0000;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign wb_valid   = wb_valid_r;
    assign wb_rd      = wb_rd_r;
    assign wb_data    = wb_data_r;
    assign access_err = access_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: store lanes, load extension, latency, errors, reset mid-access.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        access_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .access_err (access_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        in_valid   = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        rd         = r;
        tick();
        in_valid   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        rd         = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_access_err", {31'd0, access_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        reset = 1'b0;
        tick();

        // 1. SW, grant held off one cycle
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
        check("sw_req", {31'd0, mem_req}, 32'd1);
        check("sw_we", {31'd0, mem_we}, 32'd1);
        check("sw_addr", mem_addr, 32'h0000_0100);
        check("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_busy", {31'd0, in_ready}, 32'd0);
        tick();
        check("sw_req_held", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sw_req_drop", {31'd0, mem_req}, 32'd0);
        check("sw_ready", {31'd0, in_ready}, 32'd1);
        check("sw_no_wb", {31'd0, wb_valid}, 32'd0);

        // 2. SB to lane 3, zero-wait grant: in_ready back 2 cycles after accept
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
        check("sb_addr", mem_addr, 32'h0000_0100);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sb_ready_lat2", {31'd0, in_ready}, 32'd1);
        check("sb_no_wb", {31'd0, wb_valid}, 32'd0);

        // 3a. LB addr 0x202, gnt then rvalid next cycle
        issue(1'b0, 3'b000, 32'h0000_0202, 32'h0, 5'd3);
        check("lb_req", {31'd0, mem_req}, 32'd1);
        check("lb_we", {31'd0, mem_we}, 32'd0);
        check("lb_wstrb", {28'd0, mem_wstrb}, 32'h0);
        check("lb_addr", mem_addr, 32'h0000_0200);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("lb_wait_req", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12F4_5678;
        tick();
        mem_rvalid = 1'b0;
        check("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("lb_wb_data", wb_data, 32'hFFFF_FFF4);
        check("lb_wb_rd", {27'd0, wb_rd}, 32'd3);
        tick();
        check("lb_wb_pulse", {31'd0, wb_valid}, 32'd0);
        check("lb_ready", {31'd0, in_ready}, 32'd1);

        // 3b. LBU same address, gnt and rvalid in the same cycle
        issue(1'b0, 3'b100, 32'h0000_0202, 32'h0, 5'd4);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12F4_5678;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("lbu_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("lbu_wb_data", wb_data, 32'h0000_00F4);
        tick();

        // 4. LH upper half, latency 3 with zero-wait memory
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0, 5'd17);
        check("lh_lat1", {31'd0, wb_valid}, 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("lh_lat2", {31'd0, wb_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("lh_lat3_valid", {31'd0, wb_valid}, 32'd1);
        check("lh_wb_data", wb_data, 32'hFFFF_8001);
        check("lh_wb_rd", {27'd0, wb_rd}, 32'd17);
        tick();

        // 4b. LHU lower half
        issue(1'b0, 3'b101, 32'h0000_0400, 32'h0, 5'd2);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_9ABC;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("lhu_wb_data", wb_data, 32'h0000_9ABC);
        tick();

        // 5. Misaligned LW: one-cycle error, no request
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd6);
        check("lw_mis_err", {31'd0, access_err}, 32'd1);
        check("lw_mis_req", {31'd0, mem_req}, 32'd0);
        check("lw_mis_wb", {31'd0, wb_valid}, 32'd0);
        check("lw_mis_busy", {31'd0, in_ready}, 32'd0);
        tick();
        check("lw_mis_err_pulse", {31'd0, access_err}, 32'd0);
        check("lw_mis_ready", {31'd0, in_ready}, 32'd1);
        check("lw_mis_req2", {31'd0, mem_req}, 32'd0);

        // 5b. Illegal store funct3 and misaligned SH
        issue(1'b1, 3'b011, 32'h0000_0100, 32'h0, 5'd0);
        check("st_f3_err", {31'd0, access_err}, 32'd1);
        check("st_f3_req", {31'd0, mem_req}, 32'd0);
        tick();
        issue(1'b1, 3'b001, 32'h0000_0101, 32'h0, 5'd0);
        check("sh_mis_err", {31'd0, access_err}, 32'd1);
        tick();

        // 5c. SH upper lanes legal
        issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd0);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;

        // 6. LW, grant delayed 3 cycles, reset in WAIT, late rvalid dropped
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check("lw_req_hold", {31'd0, mem_req}, 32'd1);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("lw_wait_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        mem_gnt    = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        check("stale_wb", {31'd0, wb_valid}, 32'd0);
        check("stale_err", {31'd0, access_err}, 32'd0);
        check("stale_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("stale_wb2", {31'd0, wb_valid}, 32'd0);
        check("stale_wb_data", wb_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
